// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter sharing one external enable-stalled pipeline among R requesters.
// Issued words carry a requester tag through a shift register aligned with the pipeline.
module pipeline_arbiter #(
    parameter int DW = 32,
    parameter int N  = 4,
    parameter int R  = 4
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            en,
    input  logic [R-1:0]    req_valid,
    input  logic [R*DW-1:0] req_data,
    output logic [R-1:0]    req_ready,
    output logic            pipe_en,
    output logic            pipe_valid_in,
    output logic [DW-1:0]   pipe_data_in,
    input  logic            pipe_valid_out,
    input  logic [DW-1:0]   pipe_data_out,
    output logic [R-1:0]    rsp_valid,
    output logic [DW-1:0]   rsp_data,
    input  logic [R-1:0]    rsp_ready,
    output logic            busy
);
    localparam int IW = $clog2(R);
    localparam int CW = $clog2(N + 1);

    logic [IW-1:0]        ptr;
    logic [IW-1:0]        gnt_id;
    logic [IW-1:0]        tag_out;
    logic [N-1:0][IW-1:0] tag;
    logic [CW-1:0]        cnt;
    logic [R-1:0]         grant;
    logic                 found;
    logic                 stall;
    logic                 accept;
    logic                 rsp_hs;

    assign tag_out = tag[N-1];
    assign stall   = pipe_valid_out & ~rsp_ready[tag_out];
    assign pipe_en = en & ~stall;

    // Search starts one past the last granted ID so every requester gets a turn.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 1; k <= R; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % R]) begin
                found                        = 1'b1;
                gnt_id                       = IW'((int'(ptr) + k) % R);
                grant[(int'(ptr) + k) % R]   = 1'b1;
            end
        end
    end

    assign req_ready     = grant & {R{pipe_en}};
    assign accept        = found & pipe_en;
    assign pipe_valid_in = |(req_valid & req_ready);
    assign pipe_data_in  = found ? req_data[int'(gnt_id)*DW +: DW] : '0;

    for (genvar i = 0; i < R; i++) begin : g_rsp
        assign rsp_valid[i] = pipe_valid_out & (tag_out == IW'(i));
    end

    assign rsp_data = pipe_data_out;
    assign rsp_hs   = |(rsp_valid & rsp_ready);
    assign busy     = (cnt != '0);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr <= IW'(R - 1);
        end else if (accept) begin
            ptr <= gnt_id;
        end
    end

    // Tags move in lockstep with the pipeline; bubble slots carry a don't-care ID.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tag <= '0;
        end else if (pipe_en) begin
            tag[0] <= gnt_id;
            for (int k = 1; k < N; k++) begin
                tag[k] <= tag[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (accept != rsp_hs) begin
            cnt <= accept ? cnt + CW'(1) : cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_arbiter.sv
// Bench for pipeline_arbiter: behavioural N-stage pipeline fixture plus a scoreboard
// model that predicts grants, stalls and responses from issue order and enabled-edge counts.
module tb_pipeline_arbiter;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int R  = 4;

    typedef logic [2*R+DW+2:0] vec_t;
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            t;
    } item_t;

    logic            clk;
    logic            nreset;
    logic            en;
    logic [R-1:0]    req_valid;
    logic [R*DW-1:0] req_data;
    logic [R-1:0]    req_ready;
    logic            pipe_en;
    logic            pipe_valid_in;
    logic [DW-1:0]   pipe_data_in;
    logic            pipe_valid_out;
    logic [DW-1:0]   pipe_data_out;
    logic [R-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [R-1:0]    rsp_ready;
    logic            busy;

    pipeline_arbiter #(.DW(DW), .N(N), .R(R)) dut (
        .clk(clk), .nreset(nreset), .en(en),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pipe_en(pipe_en), .pipe_valid_in(pipe_valid_in), .pipe_data_in(pipe_data_in),
        .pipe_valid_out(pipe_valid_out), .pipe_data_out(pipe_data_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external enable-stalled pipeline.
    logic [N-1:0]         fx_v;
    logic [N-1:0][DW-1:0] fx_d;
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fx_v <= '0;
            fx_d <= '0;
        end else if (pipe_en) begin
            fx_v <= {fx_v[N-2:0], pipe_valid_in};
            fx_d <= {fx_d[N-2:0], pipe_data_in};
        end
    end
    assign pipe_valid_out = fx_v[N-1];
    assign pipe_data_out  = fx_d[N-1];

    int    checks = 0;
    int    errors = 0;
    item_t sb[$];
    int    m_ptr;
    int    en_edges;

    logic [R-1:0]  e_req_ready, e_rsp_valid;
    logic          e_pipe_en, e_valid_in, e_busy;
    logic [DW-1:0] e_data_in, e_rsp_data;
    int            e_g;

    function automatic int head_out();
        if (sb.size() > 0 && en_edges - sb[0].t == N) return sb[0].id;
        return -1;
    endfunction

    function automatic vec_t obs();
        return {req_ready, pipe_en, pipe_valid_in, pipe_data_in, rsp_valid, busy};
    endfunction

    function automatic vec_t expv();
        return {e_req_ready, e_pipe_en, e_valid_in, e_data_in, e_rsp_valid, e_busy};
    endfunction

    task automatic model_reset();
        sb.delete();
        m_ptr    = R - 1;
        en_edges = 0;
    endtask

    // Expected outputs from the scoreboard: the oldest word is at the output once it
    // has seen N enabled edges since issue.
    task automatic predict();
        int h;
        h = head_out();
        e_rsp_valid = '0;
        e_rsp_data  = '0;
        if (h >= 0) begin
            e_rsp_valid[h] = 1'b1;
            e_rsp_data     = sb[0].data;
        end
        e_pipe_en = en && !(h >= 0 && !rsp_ready[h]);
        e_g = -1;
        for (int k = 1; k <= R; k++) begin
            if (e_g < 0 && req_valid[(m_ptr + k) % R]) e_g = (m_ptr + k) % R;
        end
        e_req_ready = '0;
        if (e_g >= 0 && e_pipe_en) e_req_ready[e_g] = 1'b1;
        e_valid_in = (e_req_ready != '0);
        e_data_in  = (e_g >= 0) ? req_data[e_g*DW +: DW] : '0;
        e_busy     = (sb.size() != 0);
    endtask

    task automatic advance();
        logic acc, hs;
        acc = e_valid_in;
        hs  = |(e_rsp_valid & rsp_ready);
        @(posedge clk);
        if (hs) void'(sb.pop_front());
        if (acc) begin
            sb.push_back('{e_g, e_data_in, en_edges});
            m_ptr = e_g;
        end
        if (e_pipe_en) en_edges++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) begin
            #1 predict();
            advance();
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < R; i++) req_data[i*DW +: DW] = $urandom;
    endtask

    task automatic test_reset();
        nreset = 1'b1; en = 1'b1; req_valid = '0; req_data = '0; rsp_ready = '1;
        #2 nreset = 1'b0;
        #1;
        checks++;
        if (obs() !== {4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs(), {4'b0000, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0});
        end
        rand_data();
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || pipe_data_in !== req_data[DW-1:0]) begin
            errors++; $display("FAIL reset_priority req_ready %b data %h exp 0001 %h", req_ready, pipe_data_in, req_data[DW-1:0]);
        end
        req_valid = '0;
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_all_requesters();
        int nrsp;
        logic [R-1:0] oh;
        nrsp = 0;
        for (int c = 0; c < 12 + N + 2; c++) begin
            req_valid = (c < 12) ? '1 : '0;
            rand_data();
            #1 predict();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL all c%0d got %h exp %h", c, obs(), expv()); end
            if (e_rsp_valid != '0) begin
                checks++;
                if (rsp_data !== e_rsp_data) begin errors++; $display("FAIL all_data c%0d got %h exp %h", c, rsp_data, e_rsp_data); end
            end
            if (c < 12) begin
                oh = '0; oh[c % R] = 1'b1;
                checks++;
                if (req_ready !== oh) begin errors++; $display("FAIL all_order c%0d got %b exp %b", c, req_ready, oh); end
            end
            if (rsp_valid != '0) begin
                oh = '0; oh[nrsp % R] = 1'b1;
                checks++;
                if (rsp_valid !== oh) begin errors++; $display("FAIL all_rsp_order n%0d got %b exp %b", nrsp, rsp_valid, oh); end
                nrsp++;
            end
            advance();
        end
        checks++;
        if (nrsp != 12) begin errors++; $display("FAIL all_rsp_count got %0d exp 12", nrsp); end
    endtask

    task automatic test_single();
        for (int c = 0; c < N + 12; c++) begin
            req_valid = (c < 10) ? 4'b0001 : 4'b0000;
            req_data  = '0;
            req_data[DW-1:0] = DW'(3 * (c + 1));
            #1 predict();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL single c%0d got %h exp %h", c, obs(), expv()); end
            checks++;
            if (c >= N && c < N + 10) begin
                if (rsp_valid !== 4'b0001 || rsp_data !== DW'(3 * (c - N + 1))) begin
                    errors++; $display("FAIL single_rsp c%0d got %b %h exp 0001 %h", c, rsp_valid, rsp_data, DW'(3 * (c - N + 1)));
                end
            end else if (rsp_valid !== 4'b0000) begin
                errors++; $display("FAIL single_idle c%0d got %b exp 0000", c, rsp_valid);
            end
            advance();
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        int left;
        logic stalling;
        left = 5;
        for (int c = 0; c < 25; c++) begin
            req_valid = (c < 10) ? 4'b0111 : 4'b0000;
            rand_data();
            stalling = (head_out() == 2 && left > 0);
            rsp_ready = stalling ? 4'b1011 : 4'b1111;
            #1 predict();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL bp c%0d got %h exp %h", c, obs(), expv()); end
            if (e_rsp_valid != '0) begin
                checks++;
                if (rsp_data !== e_rsp_data) begin errors++; $display("FAIL bp_data c%0d got %h exp %h", c, rsp_data, e_rsp_data); end
            end
            if (stalling) begin
                checks++;
                if (pipe_en !== 1'b0 || req_ready !== 4'b0000 || rsp_valid !== 4'b0100) begin
                    errors++; $display("FAIL bp_stall c%0d pipe_en %b req_ready %b rsp_valid %b exp 0 0000 0100", c, pipe_en, req_ready, rsp_valid);
                end
                left--;
            end
            advance();
        end
        rsp_ready = '1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain busy %b exp 0", busy); end
    endtask

    task automatic test_sparse();
        logic [R-1:0] prev;
        prev = '0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 4'b1010;
            rand_data();
            #1 predict();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL sparse c%0d got %h exp %h", c, obs(), expv()); end
            checks++;
            if (!((req_ready === 4'b0010 && prev !== 4'b0010) || (req_ready === 4'b1000 && prev !== 4'b1000))) begin
                errors++; $display("FAIL sparse_alt c%0d got %b prev %b", c, req_ready, prev);
            end
            prev = req_ready;
            advance();
        end
        idle(N + 2);
    endtask

    task automatic test_enable();
        for (int c = 0; c < 12 + N + 5; c++) begin
            req_valid = (c < 12) ? '1 : '0;
            rand_data();
            en = !(c >= 5 && c < 8);
            rsp_ready = en ? '1 : '0;
            #1 predict();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL enable c%0d got %h exp %h", c, obs(), expv()); end
            if (e_rsp_valid != '0) begin
                checks++;
                if (rsp_data !== e_rsp_data) begin errors++; $display("FAIL enable_data c%0d got %h exp %h", c, rsp_data, e_rsp_data); end
            end
            if (!en) begin
                checks++;
                if (pipe_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                    errors++; $display("FAIL enable_frozen c%0d pipe_en %b req_ready %b busy %b exp 0 0000 1", c, pipe_en, req_ready, busy);
                end
            end
            advance();
        end
        en = 1'b1; rsp_ready = '1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL enable_drain busy %b exp 0", busy); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 150; c++) begin
            en = ($urandom_range(9) != 0);
            req_valid = R'($urandom);
            rand_data();
            for (int i = 0; i < R; i++) rsp_ready[i] = en && ($urandom_range(3) != 0);
            #1 predict();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL random c%0d got %h exp %h", c, obs(), expv()); end
            if (e_rsp_valid != '0) begin
                checks++;
                if (rsp_data !== e_rsp_data) begin errors++; $display("FAIL random_data c%0d got %h exp %h", c, rsp_data, e_rsp_data); end
            end
            advance();
        end
        en = 1'b1; rsp_ready = '1;
        idle(2 * N + 4);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL random_drain busy %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            req_valid = '1;
            rand_data();
            #1 predict();
            advance();
        end
        req_valid = '0;
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_inflight busy %b exp 1", busy); end
        nreset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || pipe_valid_in !== 1'b0) begin
            errors++; $display("FAIL mid_reset rsp_valid %b busy %b valid_in %b exp 0000 0 0", rsp_valid, busy, pipe_valid_in);
        end
        model_reset();
        @(negedge clk);
        nreset = 1'b1;
        for (int c = 0; c < N + 4; c++) begin
            req_valid = (c == 0) ? '1 : '0;
            rand_data();
            #1 predict();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL mid_after c%0d got %h exp %h", c, obs(), expv()); end
            if (c == 0) begin
                checks++;
                if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", req_ready); end
            end
            advance();
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_drain busy %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_all_requesters();
        test_single();
        test_backpressure();
        test_sparse();
        test_enable();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
